// File: rtl/logic_unit_arbiter_pkg.sv
// logic_unit_arbiter_pkg: op codes, FSM states and legality helper for the shared logic unit.
package logic_pkg;
  localparam logic [3:0] LOGIC_AND = 4'b1000;
  localparam logic [3:0] LOGIC_OR = 4'b1110;
  localparam logic [3:0] LOGIC_XOR = 4'b0110;
  localparam logic [3:0] LOGIC_NOR = 4'b0001;
  localparam logic [3:0] LOGIC_PASSA = 4'b1010;
  typedef enum logic {IDLE, FULL} state_t;
  function automatic logic op_legal(input logic [3:0] c);
    return c == LOGIC_AND || c == LOGIC_OR || c == LOGIC_XOR || c == LOGIC_NOR || c == LOGIC_PASSA;
  endfunction
endpackage

// File: rtl/logic_unit_arbiter_if.sv
// logic_unit_arbiter_if: request/response bundle; rsp_err exists only with LOGIC_ARB_ILLEGAL_OP_EN.
interface logic_unit_arbiter_if #(parameter int NUM_REQ = 2, parameter int WIDTH = 32, parameter int IDW = 1);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_ctrl;
  logic rsp_valid;
  logic rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [IDW-1:0] rsp_id;
  logic [15:0] op_count;
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
  logic rsp_err;
  modport master(output req_valid, req_a, req_b, req_ctrl, rsp_ready,
                 input req_ready, rsp_valid, rsp_data, rsp_id, op_count, rsp_err);
  modport slave(input req_valid, req_a, req_b, req_ctrl, rsp_ready,
                output req_ready, rsp_valid, rsp_data, rsp_id, op_count, rsp_err);
`else
  modport master(output req_valid, req_a, req_b, req_ctrl, rsp_ready,
                 input req_ready, rsp_valid, rsp_data, rsp_id, op_count);
  modport slave(input req_valid, req_a, req_b, req_ctrl, rsp_ready,
                output req_ready, rsp_valid, rsp_data, rsp_id, op_count);
`endif
endinterface

// File: rtl/logic_unit_arbiter_rr_pick.sv
// logic_rr_pick: first requester at or after ptr (mod N) wins; one-hot grant plus its index.
module logic_rr_pick #(parameter int N = 2, parameter int IW = 1) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);
  logic [IW-1:0] j;
  assign any = |req;
  // scan from farthest to nearest so the nearest hit to ptr is the last write
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin shared 32-bit logic unit with one registered result slot.
// Define LOGIC_ARB_ILLEGAL_OP_EN to add rsp_err flagging unknown op codes.
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH = 32,
  parameter int IDW = 1
) (
  input logic clk,
  input logic rst_n,
  logic_unit_arbiter_if.slave bus
);
  state_t state;
  logic [IDW-1:0] rr_ptr, idx, id_q;
  logic [NUM_REQ-1:0] grant;
  logic any, can_load, xfer, valid_q;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [3:0] c_arr [NUM_REQ];
  logic [WIDTH-1:0] a, b, res, data_q;
  logic [3:0] ctrl;
  logic [15:0] cnt_q;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
    assign c_arr[i] = bus.req_ctrl[i*4 +: 4];
  end
  logic_rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req(bus.req_valid), .ptr(rr_ptr), .grant(grant), .idx(idx), .any(any)
  );
  assign a = a_arr[idx];
  assign b = b_arr[idx];
  assign ctrl = c_arr[idx];
  assign can_load = state == IDLE || bus.rsp_ready;
  assign xfer = any && can_load;
  // rst_n gate keeps req_ready low while reset is asserted
  assign bus.req_ready = grant & {NUM_REQ{can_load && rst_n}};
  always_comb begin
    res = '0;
    case (ctrl)
      LOGIC_AND: res = a & b;
      LOGIC_OR: res = a | b;
      LOGIC_XOR: res = a ^ b;
      LOGIC_NOR: res = ~(a | b);
      LOGIC_PASSA: res = a;
      default: res = '0;
    endcase
  end
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
  logic err_q;
  assign bus.rsp_err = err_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      valid_q <= 1'b0;
      data_q <= '0;
      id_q <= '0;
      cnt_q <= '0;
      rr_ptr <= '0;
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
      err_q <= 1'b0;
`endif
    end else if (xfer) begin
      state <= FULL;
      valid_q <= 1'b1;
      data_q <= res;
      id_q <= idx;
      cnt_q <= cnt_q + 16'd1;
      rr_ptr <= idx == IDW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
      err_q <= !op_legal(ctrl);
`endif
    end else if (state == FULL && bus.rsp_ready) begin
      state <= IDLE;
      valid_q <= 1'b0;
    end
  end
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_id = id_q;
  assign bus.op_count = cnt_q;
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed vector table plus reset and op_count wrap sequences.
module tb_logic_unit_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int errs = 0;
  always #5 clk = ~clk;
  logic_unit_arbiter_if #(.NUM_REQ(2), .WIDTH(32), .IDW(1)) bus ();
  logic_unit_arbiter #(.NUM_REQ(2), .WIDTH(32), .IDW(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [1:0] v;
    logic [31:0] a0, b0;
    logic [3:0] c0;
    logic [31:0] a1, b1;
    logic [3:0] c1;
    logic rr;
    logic [1:0] er;
    logic ev;
    logic [31:0] ed;
    logic eid;
    logic [15:0] ec;
    logic ee;
  } vec_t;
  localparam logic [31:0] A = 32'hF0F0_F0F0;
  localparam logic [31:0] B = 32'h0FF0_0FF0;
  localparam logic [3:0] AN = 4'b1000, OR = 4'b1110, XR = 4'b0110, NR = 4'b0001, PA = 4'b1010, IL = 4'b1111;
  vec_t vt [17];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic drive(input logic [1:0] v, input logic [31:0] a0, b0, input logic [3:0] c0,
                       input logic [31:0] a1, b1, input logic [3:0] c1, input logic rr);
    bus.req_valid = v;
    bus.req_a = {a1, a0};
    bus.req_b = {b1, b0};
    bus.req_ctrl = {c1, c0};
    bus.rsp_ready = rr;
  endtask
  initial begin
    vt[0] = '{2'b01, A, B, AN, 0, 0, 0, 1, 2'b01, 1, 32'h00F0_00F0, 0, 1, 0};
    vt[1] = '{2'b11, A, B, AN, A, B, OR, 1, 2'b10, 1, 32'hFFF0_FFF0, 1, 2, 0};
    vt[2] = '{2'b11, A, B, AN, A, B, OR, 1, 2'b01, 1, 32'h00F0_00F0, 0, 3, 0};
    vt[3] = '{2'b11, A, B, AN, A, B, OR, 1, 2'b10, 1, 32'hFFF0_FFF0, 1, 4, 0};
    vt[4] = '{2'b11, A, B, AN, A, B, OR, 1, 2'b01, 1, 32'h00F0_00F0, 0, 5, 0};
    vt[5] = '{2'b10, A, B, AN, A, B, OR, 0, 2'b00, 1, 32'h00F0_00F0, 0, 5, 0};
    vt[6] = '{2'b10, A, B, AN, A, B, OR, 0, 2'b00, 1, 32'h00F0_00F0, 0, 5, 0};
    vt[7] = '{2'b10, A, B, AN, A, B, OR, 0, 2'b00, 1, 32'h00F0_00F0, 0, 5, 0};
    vt[8] = '{2'b10, A, B, AN, A, B, OR, 1, 2'b10, 1, 32'hFFF0_FFF0, 1, 6, 0};
    vt[9] = '{2'b01, 0, 0, NR, 0, 0, 0, 1, 2'b01, 1, 32'hFFFF_FFFF, 0, 7, 0};
    vt[10] = '{2'b01, 32'h1234_5678, 32'hFFFF_FFFF, PA, 0, 0, 0, 1, 2'b01, 1, 32'h1234_5678, 0, 8, 0};
    vt[11] = '{2'b10, 0, 0, 0, A, B, XR, 1, 2'b10, 1, 32'hFF00_FF00, 1, 9, 0};
    vt[12] = '{2'b01, A, B, IL, 0, 0, 0, 1, 2'b01, 1, 32'h0, 0, 10, 1};
    vt[13] = '{2'b00, A, B, IL, 0, 0, 0, 1, 2'b00, 0, 32'h0, 0, 10, 1};
    vt[14] = '{2'b00, A, B, IL, 0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 10, 1};
    vt[15] = '{2'b10, 0, 0, 0, A, B, XR, 0, 2'b10, 1, 32'hFF00_FF00, 1, 11, 0};
    vt[16] = '{2'b11, A, B, NR, A, B, OR, 1, 2'b01, 1, 32'h000F_000F, 0, 12, 0};
    drive(2'b01, A, B, AN, 0, 0, 0, 1'b1);
    #1;
    chk("reset rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("reset rsp_data", bus.rsp_data, 0);
    chk("reset rsp_id", {31'd0, bus.rsp_id}, 0);
    chk("reset op_count", {16'd0, bus.op_count}, 0);
    chk("reset req_ready", {30'd0, bus.req_ready}, 0);
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
    chk("reset rsp_err", {31'd0, bus.rsp_err}, 0);
`endif
    @(posedge clk);
    #1;
    chk("reset hold rsp_valid", {31'd0, bus.rsp_valid}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].v, vt[i].a0, vt[i].b0, vt[i].c0, vt[i].a1, vt[i].b1, vt[i].c1, vt[i].rr);
      #1;
      chk($sformatf("v%0d req_ready", i), {30'd0, bus.req_ready}, {30'd0, vt[i].er});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d rsp_valid", i), {31'd0, bus.rsp_valid}, {31'd0, vt[i].ev});
      chk($sformatf("v%0d rsp_data", i), bus.rsp_data, vt[i].ed);
      chk($sformatf("v%0d rsp_id", i), {31'd0, bus.rsp_id}, {31'd0, vt[i].eid});
      chk($sformatf("v%0d op_count", i), {16'd0, bus.op_count}, {16'd0, vt[i].ec});
`ifdef LOGIC_ARB_ILLEGAL_OP_EN
      chk($sformatf("v%0d rsp_err", i), {31'd0, bus.rsp_err}, {31'd0, vt[i].ee});
`endif
    end
    drive(2'b11, A, B, AN, A, B, OR, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", {31'd0, bus.rsp_valid}, 0);
    chk("midrst rsp_data", bus.rsp_data, 0);
    chk("midrst rsp_id", {31'd0, bus.rsp_id}, 0);
    chk("midrst op_count", {16'd0, bus.op_count}, 0);
    chk("midrst req_ready", {30'd0, bus.req_ready}, 0);
    @(posedge clk);
    #1;
    chk("midrst edge req_ready", {30'd0, bus.req_ready}, 0);
    chk("midrst edge rsp_valid", {31'd0, bus.rsp_valid}, 0);
    rst_n = 1'b1;
    #1;
    chk("post rst rr_ptr grant", {30'd0, bus.req_ready}, 1);
    @(posedge clk);
    #1;
    chk("post rst rsp_id", {31'd0, bus.rsp_id}, 0);
    chk("post rst rsp_data", bus.rsp_data, 32'h00F0_00F0);
    chk("post rst op_count", {16'd0, bus.op_count}, 1);
    drive(2'b01, A, B, AN, 0, 0, 0, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("op_count max", {16'd0, bus.op_count}, 32'hFFFF);
    @(posedge clk);
    #1;
    chk("op_count wrap", {16'd0, bus.op_count}, 0);
    chk("wrap rsp_valid", {31'd0, bus.rsp_valid}, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
